// File: rtl/uart_byte_tx_if.sv
// Byte-send handshake and serial line between a UART byte transmitter and its user.
// The user side drives the byte, baud select and request; the transmitter drives line and status.
interface uart_byte_tx_if;
    logic [2:0] Baud_Set;
    logic [7:0] Data_Byte;
    logic       Send_En;
    logic       Rs232_Tx;
    logic       Tx_Done;
    logic       Uart_State;

    modport master (
        output Baud_Set, Data_Byte, Send_En,
        input  Rs232_Tx, Tx_Done, Uart_State
    );

    modport slave (
        input  Baud_Set, Data_Byte, Send_En,
        output Rs232_Tx, Tx_Done, Uart_State
    );
endinterface

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: one 8N1 frame (start, 8 data bits LSB first, stop) per accepted Send_En.
// Byte and bit period are captured at acceptance, so input changes mid-frame never disturb the line.
module uart_byte_tx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input logic           Clk,
    input logic           Rst,
    uart_byte_tx_if.slave Bus
);
    localparam int P_9600   = CLK_FREQ / 9600;
    localparam int P_19200  = CLK_FREQ / 19200;
    localparam int P_38400  = CLK_FREQ / 38400;
    localparam int P_57600  = CLK_FREQ / 57600;
    localparam int P_115200 = CLK_FREQ / 115200;
    // The 9600-baud period is the longest, so it sizes the period counter.
    localparam int CNT_W    = $clog2(P_9600 + 1);

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    state_t     state, state_nxt;
    cnt_t       period_cnt, period_cnt_nxt;
    cnt_t       period_last, period_last_nxt;
    cnt_t       period_dec;
    logic [3:0] bit_idx, bit_idx_nxt;
    logic [7:0] data_q, data_nxt;
    logic [9:0] frame_word;
    logic       tx_q, tx_nxt;
    logic       done_q, done_nxt;

    always_comb begin
        case (Bus.Baud_Set)
            3'd1:    period_dec = cnt_t'(P_19200);
            3'd2:    period_dec = cnt_t'(P_38400);
            3'd3:    period_dec = cnt_t'(P_57600);
            3'd4:    period_dec = cnt_t'(P_115200);
            default: period_dec = cnt_t'(P_9600);
        endcase
    end

    // Line value for each bit index: stop, data MSB..LSB, start.
    assign frame_word = {1'b1, data_q, 1'b0};

    always_ff @(posedge Clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (Rst) begin
            state       <= IDLE;
            period_cnt  <= '0;
            period_last <= '0;
            bit_idx     <= '0;
            data_q      <= '0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            period_cnt  <= period_cnt_nxt;
            period_last <= period_last_nxt;
            bit_idx     <= bit_idx_nxt;
            data_q      <= data_nxt;
            tx_q        <= tx_nxt;
            done_q      <= done_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt       = state;
        period_cnt_nxt  = period_cnt;
        period_last_nxt = period_last;
        bit_idx_nxt     = bit_idx;
        data_nxt        = data_q;
        tx_nxt          = tx_q;
        done_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (Bus.Send_En) begin
                    state_nxt       = SEND;
                    data_nxt        = Bus.Data_Byte;
                    period_last_nxt = period_dec - 1'b1;
                    period_cnt_nxt  = '0;
                    bit_idx_nxt     = '0;
                    tx_nxt          = 1'b0;
                end
            end
            SEND: begin
                if (period_cnt == period_last) begin
                    period_cnt_nxt = '0;
                    if (bit_idx == 4'd9) begin
                        state_nxt   = IDLE;
                        bit_idx_nxt = '0;
                        tx_nxt      = 1'b1;
                        done_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                        tx_nxt      = frame_word[bit_idx + 4'd1];
                    end
                end else begin
                    period_cnt_nxt = period_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Bus.Rs232_Tx   = tx_q;
    assign Bus.Tx_Done    = done_q;
    assign Bus.Uart_State = (state == SEND);
endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: a default-clock instance for the directed frame cases and a slow-clock
// instance for the randomized loopback, both decoded by a behavioural receiver against a frame queue.
`timescale 1ns/1ps
module tb_uart_byte_tx;
    localparam int FREQ_A = 50_000_000;
    localparam int FREQ_B = 230_400;
    localparam bit A = 1'b0;
    localparam bit B = 1'b1;

    typedef struct {
        logic [7:0] data;
        int         n;
        bit         b2b;
    } frame_t;

    logic       Clk;
    logic       Rst;
    logic [2:0] baud [2];
    logic [7:0] data [2];
    logic       en   [2];
    logic       line [2];
    logic       done [2];
    logic       busy [2];

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q [2][$];
    bit     in_frame [2]    = '{1'b0, 1'b0};
    int     stray [2]       = '{0, 0};
    int     frames_done [2] = '{0, 0};
    bit     mon_en = 1'b0;
    bit     seen;

    uart_byte_tx_if bus_a ();
    uart_byte_tx_if bus_b ();

    assign bus_a.Baud_Set  = baud[0];
    assign bus_a.Data_Byte = data[0];
    assign bus_a.Send_En   = en[0];
    assign line[0]         = bus_a.Rs232_Tx;
    assign done[0]         = bus_a.Tx_Done;
    assign busy[0]         = bus_a.Uart_State;
    assign bus_b.Baud_Set  = baud[1];
    assign bus_b.Data_Byte = data[1];
    assign bus_b.Send_En   = en[1];
    assign line[1]         = bus_b.Rs232_Tx;
    assign done[1]         = bus_b.Tx_Done;
    assign busy[1]         = bus_b.Uart_State;

    uart_byte_tx #(.CLK_FREQ(FREQ_A)) dut_a (.Clk(Clk), .Rst(Rst), .Bus(bus_a.slave));
    uart_byte_tx #(.CLK_FREQ(FREQ_B)) dut_b (.Clk(Clk), .Rst(Rst), .Bus(bus_b.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference bit period: clock frequency divided by the selected baud rate, rounded down.
    function automatic int bit_period(input bit d, input logic [2:0] bs);
        int rate;
        case (bs)
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            3'd4:    rate = 115200;
            default: rate = 9600;
        endcase
        return (d ? FREQ_B : FREQ_A) / rate;
    endfunction

    function automatic logic frame_bit(input logic [7:0] byte_v, input int b);
        logic [9:0] word;
        word = {1'b1, byte_v, 1'b0};
        return word[b[3:0]];
    endfunction

    // Present a one-cycle request; an accepted request queues its expected frame.
    task automatic send_pulse(input bit d, input logic [7:0] byte_v, input logic [2:0] bs,
                              input bit accept, input bit b2b);
        data[d] = byte_v;
        baud[d] = bs;
        en[d]   = 1'b1;
        if (accept) exp_q[d].push_back('{data: byte_v, n: bit_period(d, bs), b2b: b2b});
        @(posedge Clk); #1;
        en[d] = 1'b0;
    endtask

    task automatic wait_drain(input bit d, input int budget);
        int i;
        i = 0;
        while ((exp_q[d].size() != 0 || in_frame[d]) && i < budget) begin
            @(posedge Clk); #1;
            i++;
        end
        check($sformatf("dut%0d drain_in_time", d),
              int'(exp_q[d].size() == 0 && !in_frame[d]), 1);
        exp_q[d].delete();
    endtask

    task automatic wait_done(input bit d, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge Clk); #1;
            got = done[d];
        end
        check($sformatf("dut%0d done_seen", d), int'(got), 1);
    endtask

    // Behavioural receiver: samples the line every cycle on the falling edge.
    task automatic monitor(input bit d);
        frame_t     f;
        int         gap;
        int         bad;
        int         b;
        logic [7:0] rx;
        bit         aborted;
        gap = -1;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                gap = -1;
                continue;
            end
            if (line[d] === 1'b1) begin
                if (done[d] !== 1'b0 || busy[d] !== 1'b0) stray[d]++;
                if (gap >= 0) gap++;
                continue;
            end
            check($sformatf("dut%0d frame_expected", d), int'(exp_q[d].size() > 0), 1);
            if (exp_q[d].size() == 0) begin
                while (line[d] !== 1'b1 || busy[d] !== 1'b0) @(negedge Clk);
                gap = -1;
                continue;
            end
            f           = exp_q[d].pop_front();
            in_frame[d] = 1'b1;
            if (f.b2b) check($sformatf("dut%0d b2b_gap", d), gap, 0);
            bad     = 0;
            aborted = 1'b0;
            rx      = '0;
            for (int s = 0; s < 10 * f.n; s++) begin
                if (s > 0) @(negedge Clk);
                b = s / f.n;
                if (line[d] !== frame_bit(f.data, b) || busy[d] !== 1'b1 || done[d] !== 1'b0) bad++;
                if (b >= 1 && b <= 8 && (s % f.n) == f.n / 2) rx[3'(b - 1)] = line[d];
                if (Rst) begin
                    aborted = 1'b1;
                    break;
                end
            end
            check($sformatf("dut%0d bit_timing 0x%02h", d, f.data), bad, 0);
            @(negedge Clk);
            if (aborted) begin
                // After an abort: line high, not busy, no completion pulse.
                check($sformatf("dut%0d abort_state", d), int'({line[d], busy[d], done[d]}), 'b100);
                gap = -1;
            end else begin
                check($sformatf("dut%0d rx_byte", d), int'(rx), int'(f.data));
                check($sformatf("dut%0d frame_end", d), int'({line[d], busy[d], done[d]}), 'b101);
                frames_done[d]++;
                gap = 0;
            end
            in_frame[d] = 1'b0;
        end
    endtask

    initial begin wait (mon_en); monitor(A); end
    initial begin wait (mon_en); monitor(B); end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            baud[d] = 3'd0;
            data[d] = 8'h00;
            en[d]   = 1'b1;   // requests during reset must be ignored
        end
        repeat (3) @(posedge Clk);
        #1;
        Rst   = 1'b0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        @(negedge Clk);
        check("dut0 reset_state", int'({line[0], busy[0], done[0]}), 'b100);
        check("dut1 reset_state", int'({line[1], busy[1], done[1]}), 'b100);
        mon_en = 1'b1;
        repeat (20) @(posedge Clk);
        #1;

        // Single frame at 115200.
        send_pulse(A, 8'hA5, 3'd4, 1'b1, 1'b0);
        wait_drain(A, 4500);

        // Request 100 clocks into a frame is dropped; byte input changes are harmless.
        send_pulse(A, 8'h3C, 3'd4, 1'b1, 1'b0);
        repeat (99) begin @(posedge Clk); #1; end
        send_pulse(A, 8'hC3, 3'd4, 1'b0, 1'b0);
        wait_drain(A, 4500);

        // Back-to-back: second request presented in the Tx_Done cycle.
        send_pulse(A, 8'hAA, 3'd4, 1'b1, 1'b0);
        wait_done(A, 4400, seen);
        send_pulse(A, 8'h55, 3'd4, 1'b1, 1'b1);
        wait_drain(A, 4500);

        // Reset during bit index 4, then a clean frame.
        send_pulse(A, 8'h96, 3'd4, 1'b1, 1'b0);
        repeat (4 * 434 + 200) begin @(posedge Clk); #1; end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        wait_drain(A, 10);
        send_pulse(A, 8'h5A, 3'd4, 1'b1, 1'b0);
        wait_drain(A, 4500);

        // Slowest rate with baud select and byte changed mid-frame.
        send_pulse(B, 8'h00, 3'd0, 1'b1, 1'b0);
        repeat (60) begin @(posedge Clk); #1; end
        baud[1] = 3'd4;
        data[1] = 8'hFF;
        wait_drain(B, 400);

        // Loopback: 256 consecutive bytes over all rates, random spacing and aliased selects.
        for (int v = 0; v < 256; v++) begin
            logic [2:0] bs;
            bit         b2b;
            bs = 3'(v % 5);
            if (bs == 3'd0 && $urandom_range(0, 3) == 0) bs = 3'($urandom_range(5, 7));
            b2b = (v > 0) && ($urandom_range(0, 1) == 1);
            if (b2b) begin
                wait_done(B, 300, seen);
            end else begin
                if (v > 0) wait_drain(B, 300);
                repeat (int'($urandom_range(0, 3))) begin @(posedge Clk); #1; end
            end
            send_pulse(B, 8'(v), bs, 1'b1, b2b);
        end
        wait_drain(B, 300);

        check("dut0 frames_completed", frames_done[0], 5);
        check("dut1 frames_completed", frames_done[1], 257);
        check("dut0 idle_glitches", stray[0], 0);
        check("dut1 idle_glitches", stray[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
